// File: rtl/event_frame_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : event_frame_packer_pkg
// Brief    : Shared state encoding, default sync byte and frame length helper
// Revision : 1.0
// ============================================================================
package event_frame_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] C_SYNC_BYTE_DEFAULT = 8'hA5;

  // SYNC + SEQ + one byte per channel + CHK
  function automatic int frame_len(input int num_ch);
    return num_ch + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/event_frame_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : event_frame_packer_if
// Brief    : Counter snapshot / UART transmit signal bundle for the packer
// Revision : 1.0
// ============================================================================
interface event_frame_packer_if #(
  parameter int NUM_CH = 8
);
  logic                  minPul;
  logic [NUM_CH*8-1:0]   counts;
  logic                  cntClear;
  logic [7:0]            txData;
  logic                  txWr;
  logic                  txBusy;
  logic                  frameActive;
  logic [7:0]            overrun;

  modport master (
    input  minPul, counts, txBusy,
    output cntClear, txData, txWr, frameActive, overrun
  );

  modport slave (
    output minPul, counts, txBusy,
    input  cntClear, txData, txWr, frameActive, overrun
  );
endinterface
`default_nettype wire

// File: rtl/event_frame_packer_frame_byte_mux.sv
`default_nettype none
// ============================================================================
// Module   : frame_byte_mux
// Brief    : Selects frame byte[idx] from SYNC, SEQ, snapshot bytes and CHK
// Revision : 1.0
// ============================================================================
module frame_byte_mux #(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = 4
) (
  input  wire logic [IDX_W-1:0]    i_idx,
  input  wire logic [7:0]          i_sync,
  input  wire logic [7:0]          i_seq,
  input  wire logic [NUM_CH*8-1:0] i_snap,
  input  wire logic [7:0]          i_chk,
  output logic      [7:0]          o_byte
);

  always_comb begin
    o_byte = 8'h00;
    if (int'(i_idx) == 0) begin
      o_byte = i_sync;
    end else if (int'(i_idx) == 1) begin
      o_byte = i_seq;
    end else if (int'(i_idx) == NUM_CH + 2) begin
      o_byte = i_chk;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(i_idx) == i + 2) begin
          o_byte = i_snap[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/event_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : event_frame_packer
// Brief    : Snapshots channel counters on minPul and streams a framed packet
//            (SYNC, SEQ, CH0..CHn-1, CHK) into the UART transmitter
// Revision : 1.0
// ============================================================================
module event_frame_packer
  import event_frame_packer_pkg::*;
#(
  parameter int         NUM_CH    = 8,
  parameter logic [7:0] SYNC_BYTE = C_SYNC_BYTE_DEFAULT
) (
  input wire logic            CLK,
  input wire logic            RST_N,
  event_frame_packer_if.master bus
);

  localparam int                 C_FRAME_LEN = frame_len(NUM_CH);
  localparam int                 C_IDX_W     = $clog2(C_FRAME_LEN);
  localparam logic [C_IDX_W-1:0] C_LAST_IDX  = C_IDX_W'(C_FRAME_LEN - 1);

  state_t               r_state;
  logic [NUM_CH*8-1:0]  r_snap;
  logic [C_IDX_W-1:0]   r_idx;
  logic [7:0]           r_seq;
  logic [7:0]           r_chk;
  logic [7:0]           r_overrun;
  logic [7:0]           r_tx_data;
  logic                 r_tx_wr;
  logic                 r_cnt_clear;
  logic                 r_frame_active;
  logic [7:0]           w_byte;

  frame_byte_mux #(
    .NUM_CH (NUM_CH),
    .IDX_W  (C_IDX_W)
  ) u_frame_byte_mux (
    .i_idx  (r_idx),
    .i_sync (SYNC_BYTE),
    .i_seq  (r_seq),
    .i_snap (r_snap),
    .i_chk  (r_chk),
    .o_byte (w_byte)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state        <= ST_IDLE;
      r_snap         <= '0;
      r_idx          <= '0;
      r_seq          <= 8'h00;
      r_chk          <= 8'h00;
      r_overrun      <= 8'h00;
      r_tx_data      <= 8'h00;
      r_tx_wr        <= 1'b0;
      r_cnt_clear    <= 1'b0;
      r_frame_active <= 1'b0;
    end else begin
      r_cnt_clear <= 1'b0;

      // A trigger outside IDLE (including the final WAIT cycle) is dropped
      if (bus.minPul && (r_state != ST_IDLE) && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.minPul) begin
            r_snap         <= bus.counts;
            r_cnt_clear    <= 1'b1;
            r_idx          <= '0;
            r_chk          <= 8'h00;
            r_frame_active <= 1'b1;
            r_state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!bus.txBusy) begin
            r_tx_wr   <= 1'b1;
            r_tx_data <= w_byte;
            // CHK covers SEQ and channel bytes only
            if ((r_idx != '0) && (r_idx != C_LAST_IDX)) begin
              r_chk <= r_chk + w_byte;
            end
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_tx_wr <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!bus.txBusy) begin
            if (r_idx == C_LAST_IDX) begin
              r_seq          <= r_seq + 8'd1;
              r_frame_active <= 1'b0;
              r_state        <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + C_IDX_W'(1);
              r_state <= ST_SEND;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cntClear    = r_cnt_clear;
  assign bus.txData      = r_tx_data;
  assign bus.txWr        = r_tx_wr;
  assign bus.frameActive = r_frame_active;
  assign bus.overrun     = r_overrun;

endmodule
`default_nettype wire
